// File: rtl/dram_be.sv
// dram_be: dual-port RAM (port 0 read, port 1 byte-enabled read/write) with clear-after-reset sequencer
module dram_be #(
   parameter int SZ = 2,
   parameter int DW = 32,
   parameter int RDREG = 0,
   parameter int CLRONRST = 1,
   parameter logic [DW-1:0] CLRVAL = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   rdy_o,
   input  logic                   we1_i,
   input  logic [DW/8-1:0]        sel1_i,
   input  logic [$clog2(SZ)-1:0]  addr0_i,
   input  logic [$clog2(SZ)-1:0]  addr1_i,
   input  logic [DW-1:0]          i1,
   output logic [DW-1:0]          o0,
   output logic [DW-1:0]          o1
);
   localparam int AW = $clog2(SZ);
   localparam int NB = DW / 8;
   localparam logic [AW-1:0] LAST = AW'(SZ - 1);
   typedef enum logic {CLR, RUN} st_t;
   st_t st_q;
   logic [AW-1:0] cnt_q;
   logic rdy_q;
   logic [DW-1:0] u [SZ];
   logic in0, in1, wen;
   logic [DW-1:0] rd0, rd1, wd;
`ifdef SIMULATION
   initial for (int i = 0; i < SZ; i++) u[i] = '0;
`endif
   assign in0 = 32'(addr0_i) < SZ;
   assign in1 = 32'(addr1_i) < SZ;
   assign rd0 = in0 ? u[addr0_i] : '0;
   assign rd1 = in1 ? u[addr1_i] : '0;
   assign wen = st_q == RUN && !rst_i && we1_i && in1;
   assign rdy_o = rdy_q;
   // Merged write word: enabled lanes from i1, remaining lanes keep the stored word
   genvar k;
   for (k = 0; k < NB; k++) begin : g_ln
      assign wd[8*k +: 8] = sel1_i[k] ? i1[8*k +: 8] : rd1[8*k +: 8];
   end
   // Clear sequencer: walk cnt over every word after reset, then raise ready
   always_ff @(posedge clk_i)
      if (rst_i) begin
         st_q <= (CLRONRST != 0) ? CLR : RUN;
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else if (st_q == CLR) begin
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            st_q <= RUN;
            rdy_q <= 1'b1;
         end
      end else
         rdy_q <= 1'b1;
   // Array update: fill with CLRVAL while clearing, byte-merged port-1 write once running
   always_ff @(posedge clk_i)
      if (!rst_i && st_q == CLR) u[cnt_q] <= CLRVAL;
      else if (wen) u[addr1_i] <= wd;
   if (RDREG != 0) begin : g_reg
      logic [DW-1:0] o0_q, o1_q;
      // Registered reads; a same-edge write is forwarded as the merged word
      always_ff @(posedge clk_i)
         if (rst_i) begin
            o0_q <= '0;
            o1_q <= '0;
         end else begin
            o0_q <= (wen && addr0_i == addr1_i) ? wd : rd0;
            o1_q <= wen ? wd : rd1;
         end
      assign o0 = o0_q;
      assign o1 = o1_q;
   end else begin : g_comb
      assign o0 = rd0;
      assign o1 = rd1;
   end
endmodule

// File: tb/tb_dram_be.sv
// tb_dram_be: four dram_be configurations on shared stimulus, checked against a behavioural model
module tb_dram_be;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1, we = 1'b0;
   logic [3:0] sel = '0, a0 = '0, a1 = '0;
   logic [31:0] din = '0;
   logic [31:0] o0 [4];
   logic [31:0] o1 [4];
   logic rdy [4];
   dram_be #(.SZ(5), .DW(32), .RDREG(0), .CLRONRST(1), .CLRVAL(32'hDEADBEEF)) u_a (
      .clk_i(clk), .rst_i(rst), .rdy_o(rdy[0]), .we1_i(we), .sel1_i(sel),
      .addr0_i(a0[2:0]), .addr1_i(a1[2:0]), .i1(din), .o0(o0[0]), .o1(o1[0]));
   dram_be #(.SZ(5), .DW(32), .RDREG(1), .CLRONRST(1), .CLRVAL(32'h0)) u_b (
      .clk_i(clk), .rst_i(rst), .rdy_o(rdy[1]), .we1_i(we), .sel1_i(sel),
      .addr0_i(a0[2:0]), .addr1_i(a1[2:0]), .i1(din), .o0(o0[1]), .o1(o1[1]));
   dram_be #(.SZ(16), .DW(32), .RDREG(0), .CLRONRST(1), .CLRVAL(32'h0BADF00D)) u_c (
      .clk_i(clk), .rst_i(rst), .rdy_o(rdy[2]), .we1_i(we), .sel1_i(sel),
      .addr0_i(a0), .addr1_i(a1), .i1(din), .o0(o0[2]), .o1(o1[2]));
   dram_be #(.SZ(4), .DW(32), .RDREG(0), .CLRONRST(0), .CLRVAL(32'h0)) u_d (
      .clk_i(clk), .rst_i(rst), .rdy_o(rdy[3]), .we1_i(we), .sel1_i(sel),
      .addr0_i(a0[1:0]), .addr1_i(a1[1:0]), .i1(din), .o0(o0[3]), .o1(o1[3]));
   int sz [4] = '{5, 5, 16, 4};
   int msk [4] = '{7, 7, 15, 3};
   bit rreg [4] = '{0, 1, 0, 0};
   bit clr [4] = '{1, 1, 1, 0};
   logic [31:0] cv [4] = '{32'hDEADBEEF, 32'h0, 32'h0BADF00D, 32'h0};
   logic [31:0] mem [4][16];
   bit kn [4][16];
   int cyc [4];
   logic [31:0] ro0 [4];
   logic [31:0] ro1 [4];
   bit rk0 [4];
   bit rk1 [4];
   int checks = 0, errs = 0;
   int n;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
      merge = o;
      for (int k = 0; k < 4; k++) if (s[k]) merge[8*k +: 8] = d[8*k +: 8];
   endfunction
   // Model one rising edge for configuration i, using the inputs present at that edge
   task automatic upd(int i);
      int x0, x1;
      x0 = int'(a0) & msk[i];
      x1 = int'(a1) & msk[i];
      if (rst) begin
         cyc[i] = 0;
         ro0[i] = '0;
         ro1[i] = '0;
         rk0[i] = 1'b1;
         rk1[i] = 1'b1;
      end else begin
         bit run, wen, k0, k1, kw;
         logic [31:0] old0, old1, nw;
         run = cyc[i] >= (clr[i] ? sz[i] : 0);
         wen = run && we && x1 < sz[i];
         old0 = x0 < sz[i] ? mem[i][x0] : '0;
         old1 = x1 < sz[i] ? mem[i][x1] : '0;
         k0 = x0 < sz[i] ? kn[i][x0] : 1'b1;
         k1 = x1 < sz[i] ? kn[i][x1] : 1'b1;
         nw = merge(old1, din, sel);
         kw = k1 || sel == 4'hF;
         ro1[i] = wen ? nw : old1;
         rk1[i] = run && (wen ? kw : k1);
         ro0[i] = (wen && x0 == x1) ? nw : old0;
         rk0[i] = run && ((wen && x0 == x1) ? kw : k0);
         if (!run) begin
            mem[i][cyc[i]] = cv[i];
            kn[i][cyc[i]] = 1'b1;
         end
         if (wen) begin
            mem[i][x1] = nw;
            kn[i][x1] = kw;
         end
         cyc[i]++;
      end
   endtask
   task automatic chk(int i);
      int x0, x1;
      bit er;
      x0 = int'(a0) & msk[i];
      x1 = int'(a1) & msk[i];
      er = cyc[i] >= (clr[i] ? sz[i] : 1);
      check($sformatf("rdy%0d", i), {31'b0, rdy[i]}, {31'b0, er});
      if (rreg[i]) begin
         if (rk0[i]) check($sformatf("o0_reg%0d", i), o0[i], ro0[i]);
         if (rk1[i]) check($sformatf("o1_reg%0d", i), o1[i], ro1[i]);
      end else begin
         if (x0 >= sz[i]) check($sformatf("o0_oor%0d", i), o0[i], 32'h0);
         else if (er && kn[i][x0]) check($sformatf("o0_rd%0d", i), o0[i], mem[i][x0]);
         if (x1 >= sz[i]) check($sformatf("o1_oor%0d", i), o1[i], 32'h0);
         else if (er && kn[i][x1]) check($sformatf("o1_rd%0d", i), o1[i], mem[i][x1]);
      end
   endtask
   task automatic chkall();
      for (int i = 0; i < 4; i++) chk(i);
   endtask
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 4; i++) upd(i);
      #1;
      chkall();
   endtask
   initial begin
      tick();
      tick();
      check("reg_rst_o0", o0[1], 32'h0);
      check("reg_rst_o1", o1[1], 32'h0);
      rst = 1'b0;
      we = 1'b1;
      a1 = 4'd0;
      sel = 4'hF;
      din = 32'h12345678;
      n = 0;
      while (!rdy[0] && n < 100) begin
         tick();
         n++;
         if (n == 3) we = 1'b0;
      end
      we = 1'b0;
      check("clr_len_a", n, 5);
      for (int k = 0; k < 8; k++) begin
         a0 = 4'(k);
         #1;
         check($sformatf("clr_a%0d", k), o0[0], k < 5 ? 32'hDEADBEEF : 32'h0);
      end
      while (!rdy[2] && n < 100) begin
         tick();
         n++;
      end
      check("clr_len_c", n, 16);
      a0 = 4'd0;
      #1;
      check("drop_c", o0[2], 32'h0BADF00D);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (!rdy[2] && n < 100) begin
         tick();
         n++;
      end
      check("midclr_len", n, 16);
      for (int k = 0; k < 16; k++) begin
         a0 = 4'(k);
         #1;
         check($sformatf("midclr_c%0d", k), o0[2], 32'h0BADF00D);
      end
      a1 = 4'd3;
      we = 1'b1;
      sel = 4'hF;
      din = 32'h11223344;
      tick();
      sel = 4'b0101;
      din = 32'hAABBCCDD;
      tick();
      we = 1'b0;
      a0 = 4'd3;
      #1;
      check("be_a", o0[0], 32'h11BB33DD);
      check("be_c", o0[2], 32'h11BB33DD);
      a0 = 4'd2;
      a1 = 4'd2;
      we = 1'b1;
      sel = 4'b0011;
      din = 32'hCAFEF00D;
      tick();
      we = 1'b0;
      check("fwd_o0", o0[1], 32'h0000F00D);
      check("fwd_o1", o1[1], 32'h0000F00D);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("noclr_rdy", {31'b0, rdy[3]}, 32'h1);
      a1 = 4'd1;
      we = 1'b1;
      sel = 4'hF;
      din = 32'h01020304;
      tick();
      din = 32'h5A5A5A5A;
      #1;
      check("rdw_old", o1[3], 32'h01020304);
      tick();
      we = 1'b0;
      check("rdw_new", o1[3], 32'h5A5A5A5A);
      repeat (400) begin
         rst = $urandom_range(0, 59) == 0;
         we = $urandom_range(0, 1) == 1;
         sel = 4'($urandom);
         a0 = 4'($urandom);
         a1 = 4'($urandom);
         din = $urandom;
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/dram_be.md
Name: dram_be

Overview:
- Parametrised successor to the team's asynchronous-read dual-port RAM.
- Port 0 is read-only; port 1 is read/write.
- Adds per-byte write enables, optional registered reads with write-first forwarding, and a hardware clear sequencer that zero-fills (or CLRVAL-fills) the array after reset.
- Used for register files, TLB/cache tag stores and scratch buffers that need a known state without a bitstream init file.

Parameters:
- SZ, 2, number of words; any value >= 2, not required to be a power of two.
- DW, 32, word width in bits; must be a multiple of 8.
- RDREG, 0, 0 = combinational reads; 1 = reads registered on clk_i, latency 1.
- CLRONRST, 1, 1 = run the clear sequence after every reset; 0 = no clear, array contents undefined.
- CLRVAL, 0, DW-bit value written to every word during clear.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous active-high reset.
- rdy_o  out  1  high when the RAM accepts writes and read data is valid.
- we1_i  in  1  port-1 write request.
- sel1_i  in  DW/8  port-1 byte-lane enables; bit k enables bits [8k+7:8k].
- addr0_i  in  clog2(SZ)  port-0 read address.
- addr1_i  in  clog2(SZ)  port-1 read/write address.
- i1  in  DW  port-1 write data.
- o0  out  DW  port-0 read data.
- o1  out  DW  port-1 read data.

Behaviour:
- State machine has two states, CLR and RUN.
  - While rst_i is high: next state is CLR if CLRONRST=1, else RUN. Clear counter cnt is set to 0 and rdy_o is 0.
  - CLR: each cycle, write CLRVAL to u[cnt] (all lanes) and increment cnt. On the cycle cnt==SZ-1, perform the last write and go to RUN.
  - rdy_o is registered and rises the cycle after the last clear write. Clear therefore takes exactly SZ cycles after rst_i falls, and rdy_o is high on cycle SZ+1.
  - CLRONRST=0: rdy_o rises the first cycle after rst_i falls.
  - rst_i asserted mid-clear: the sequence restarts from cnt=0. Partially cleared words remain but are overwritten again.
- Writes occur only in RUN.
  - At a rising edge with we1_i=1 and addr1_i<SZ, lane k of u[addr1_i] takes i1 lane k when sel1_i[k]=1; other lanes are unchanged.
  - we1_i with sel1_i=0 is a no-op.
  - we1_i during CLR or reset is ignored and dropped; there is no queueing.
- Out-of-range address (>=SZ, only possible when SZ is not a power of two): writes are ignored and reads return 0.
- Reads with RDREG=0:
  - o0 = u[addr0_i] and o1 = u[addr1_i], combinational.
  - Read-during-write on the same address returns the old word until the edge.
  - No reset value; outputs follow the array.
- Reads with RDREG=1:
  - o0 and o1 are registered and reset to 0.
  - Data sampled at edge N appears after edge N; latency is 1.
  - Write-first forwarding: if a write to addr1_i happens at the same edge, o1 gets the merged word (new enabled lanes, old other lanes).
  - The same applies to o0 when addr0_i==addr1_i.
  - o0 and o1 update during CLR but are undefined until rdy_o=1.
- Port 0 and port 1 may present the same address simultaneously without conflict, since port 0 never writes.
- Simulation only (SIMULATION defined): the array is initialised to 0 at time 0.

Test Plan:
- Clear sequence: SZ=5, CLRVAL=32'hDEADBEEF, RDREG=0. Pulse rst_i for 1 cycle, then count cycles until rdy_o=1 -> exactly 5 cycles low after reset falls, rdy_o high on cycle 6; o0 reads 32'hDEADBEEF at addresses 0..4; address 5..7 reads 0.
- Byte enables: write 32'h11223344 with sel1_i=4'hF to addr 3, then 32'hAABBCCDD with sel1_i=4'b0101 -> o0 at addr 3 reads 32'h11BB33DD.
- Registered read forwarding: RDREG=1, u[2]=32'h0. At one edge write 32'hCAFEF00D to addr 2 with sel1_i=4'b0011 and addr0_i=2 -> after that edge o0=o1=32'h0000F00D; o0 and o1 are 0 while rst_i is high.
- Reset mid-clear: SZ=16. Assert rst_i 7 cycles into the clear, release -> rdy_o low for 16 further cycles; all 16 words equal CLRVAL.
- Writes dropped when not ready: set we1_i=1 with data 32'h12345678 at addr 0 during CLR -> after rdy_o=1, o0 at addr 0 reads CLRVAL.
- CLRONRST=0, RDREG=0: rdy_o=1 one cycle after reset. Write addr 1 = 32'h5A5A5A5A -> o1 at addr 1 shows the old value before the edge and 32'h5A5A5A5A after it.
